// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcodes and the iterative multiplier's state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MULT_STEPS = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
  // correct when the result is then treated as unsigned.
  function automatic word_t abs_w(input word_t x);
    return x[WORD_W-1] ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Handshake-free port bundle between the shared ALU and its initiators.
interface alu_if;
  import cpu_types_pkg::*;

  word_t      portA;
  word_t      portB;
  aluop_t     aluop;
  word_t      outport;
  logic [3:0] flags;

  modport alu (input portA, portB, aluop, output outport, flags);
  modport tb  (output portA, portB, aluop, input outport, flags);
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative 32x32->64 shift-and-add multiplier that borrows the shared ALU adder.
// Optional signed support is compiled in with `define MULT_SIGNED_EN.
module alu_mult_seq
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  start,
  input  word_t mcand,
  input  word_t mplier,
`ifdef MULT_SIGNED_EN
  input  logic  is_signed,
`endif
  output logic  busy,
  output logic  done,
  output word_t hi,
  output word_t lo,
  alu_if.tb     aluif
);

  localparam int unsigned CNT_W = $clog2(MULT_STEPS);
  localparam int unsigned PROD_W = 2 * WORD_W;

  mult_state_t state_q, state_d;
  word_t       m_q, m_d;
  word_t       acc_hi_q, acc_hi_d;
  word_t       acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
`ifdef MULT_SIGNED_EN
  logic        neg_q, neg_d;
`endif

  word_t       port_a_c;
  word_t       port_b_c;
  logic        carry_c;
  logic [PROD_W-1:0] prod_c;

  // ALU operands: partial-product add while running, idle zeros otherwise.
  always_comb begin
    port_a_c = '0;
    port_b_c = '0;
    if (state_q == RUN) begin
      port_a_c = acc_hi_q;
      port_b_c = acc_lo_q[0] ? m_q : '0;
    end
  end

  assign aluif.portA = port_a_c;
  assign aluif.portB = port_b_c;
  assign aluif.aluop = ALU_ADD;

  // Carry out of the 32-bit add is recovered by unsigned wrap detection.
  assign carry_c = (aluif.outport < port_a_c);
  assign prod_c  = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          m_d      = mcand;
          acc_hi_d = '0;
          acc_lo_d = mplier;
          count_d  = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = 1'b0;
          if (is_signed) begin
            m_d      = abs_w(mcand);
            acc_lo_d = abs_w(mplier);
            neg_d    = mcand[WORD_W-1] ^ mplier[WORD_W-1];
          end
`endif
        end
      end
      RUN: begin
        acc_hi_d = {carry_c, aluif.outport[WORD_W-1:1]};
        acc_lo_d = {aluif.outport[0], acc_lo_q[WORD_W-1:1]};
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(MULT_STEPS - 1)) begin
`ifdef MULT_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      FIX: begin
        if (neg_q) begin
          {acc_hi_d, acc_lo_d} = PROD_W'(-prod_c);
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        hi_d    = acc_hi_q;
        lo_d    = acc_lo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Busy spans the whole operation including the done cycle.
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      m_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
